// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM states, SDARR bit positions and
// the default bus address.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX,
        ST_RX_ACK,
        ST_TX,
        ST_TX_ACK,
        ST_WAIT_STOP
    } i2c_state_e;

    localparam int SDARR_RX_VALID = 15;
    localparam int SDARR_OVERRUN  = 14;
    localparam int SDARR_UNDERRUN = 13;
    localparam int SDARR_BUSY     = 12;

    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h50;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for an asynchronous bus pin, followed by a registered
// rise/fall pulse stage. level_o is aligned with the pulses.
module i2c_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, sync_q, prev_q, rise_q, fall_q;

    // An idle I2C bus is high, so every stage resets to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
            fall_q <= ~sync_q & prev_q;
        end
    end

    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: address match, byte receive/transmit with open-drain SDA,
// and a CPU-side status/receive register plus transmit-byte register.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR = I2C_DEFAULT_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SCL_BUS,
    input  logic        SDA_IN,
    output logic        SDA_OE,
    input  logic [15:0] MDR,
    input  logic        LD_SDATR,
    input  logic        RD_SDARR,
    output logic [15:0] SDARR,
    output logic        TX_EMPTY,
    output i2c_state_e  STATE_DBG
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge u_scl (
        .clk(clk), .reset(reset), .d_i(SCL_BUS),
        .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_sync_edge u_sda (
        .clk(clk), .reset(reset), .d_i(SDA_IN),
        .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    i2c_state_e  state_q;
    logic [3:0]  bit_cnt_q;
    logic [7:0]  rx_shift_q, rx_data_q, tx_shift_q, tx_data_q;
    logic        rx_valid_q, overrun_q, underrun_q, tx_empty_q;
    logic        sda_oe_q, rw_q, ack_phase_q, nack_q;

    logic        start_det, stop_det;
    logic [7:0]  rx_byte_d, tx_next_d;
    logic        unused_mdr;

    assign start_det  = sda_fall & scl_lvl;
    assign stop_det   = sda_rise & scl_lvl;
    assign rx_byte_d  = {rx_shift_q[6:0], sda_lvl};
    // An empty transmit register means the CPU fell behind: send all-ones.
    assign tx_next_d  = tx_empty_q ? 8'hFF : tx_data_q;
    assign unused_mdr = ^MDR[15:8];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            rx_shift_q  <= 8'h00;
            rx_data_q   <= 8'h00;
            tx_shift_q  <= 8'h00;
            tx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            tx_empty_q  <= 1'b1;
            sda_oe_q    <= 1'b0;
            rw_q        <= 1'b0;
            ack_phase_q <= 1'b0;
            nack_q      <= 1'b0;
        end else begin
            if (RD_SDARR) begin
                rx_valid_q <= 1'b0;
                overrun_q  <= 1'b0;
            end
            if (stop_det) begin
                state_q  <= ST_IDLE;
                sda_oe_q <= 1'b0;
            end else if (start_det) begin
                state_q   <= ST_ADDR;
                bit_cnt_q <= 4'd0;
                sda_oe_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_ADDR: if (scl_rise) begin
                        rx_shift_q <= rx_byte_d;
                        bit_cnt_q  <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            ack_phase_q <= 1'b0;
                            rw_q        <= rx_byte_d[0];
                            state_q     <= (rx_byte_d[7:1] == ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
                        end
                    end
                    ST_ADDR_ACK: if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_oe_q    <= 1'b1;
                            ack_phase_q <= 1'b1;
                        end else if (rw_q) begin
                            // The ACK-ending fall is also when the first data bit goes out.
                            state_q    <= ST_TX;
                            sda_oe_q   <= ~tx_next_d[7];
                            tx_shift_q <= {tx_next_d[6:0], 1'b0};
                            bit_cnt_q  <= 4'd1;
                            tx_empty_q <= 1'b1;
                            if (tx_empty_q) underrun_q <= 1'b1;
                        end else begin
                            state_q   <= ST_RX;
                            sda_oe_q  <= 1'b0;
                            bit_cnt_q <= 4'd0;
                        end
                    end
                    ST_RX: if (scl_rise) begin
                        rx_shift_q <= rx_byte_d;
                        bit_cnt_q  <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            ack_phase_q <= 1'b0;
                            state_q     <= ST_RX_ACK;
                            if (!rx_valid_q) begin
                                rx_data_q  <= rx_byte_d;
                                rx_valid_q <= 1'b1;
                                nack_q     <= 1'b0;
                            end else begin
                                overrun_q <= 1'b1;
                                nack_q    <= 1'b1;
                            end
                        end
                    end
                    ST_RX_ACK: if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_oe_q    <= ~nack_q;
                            ack_phase_q <= 1'b1;
                        end else begin
                            sda_oe_q  <= 1'b0;
                            state_q   <= ST_RX;
                            bit_cnt_q <= 4'd0;
                        end
                    end
                    ST_TX: if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_q <= 1'b0;
                            state_q  <= ST_TX_ACK;
                        end else begin
                            sda_oe_q   <= ~tx_shift_q[7];
                            tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                            bit_cnt_q  <= bit_cnt_q + 4'd1;
                        end
                    end
                    ST_TX_ACK: if (scl_rise) begin
                        if (!sda_lvl) begin
                            state_q    <= ST_TX;
                            tx_shift_q <= tx_next_d;
                            bit_cnt_q  <= 4'd0;
                            tx_empty_q <= 1'b1;
                            if (tx_empty_q) underrun_q <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT_STOP;
                        end
                    end
                    default: sda_oe_q <= 1'b0;
                endcase
            end
            // Placed last so a CPU write wins over a same-cycle transmit load.
            if (LD_SDATR) begin
                tx_data_q  <= MDR[7:0];
                tx_empty_q <= 1'b0;
                underrun_q <= 1'b0;
            end
        end
    end

    always_comb begin
        SDARR                 = 16'h0000;
        SDARR[7:0]            = rx_data_q;
        SDARR[SDARR_RX_VALID] = rx_valid_q;
        SDARR[SDARR_OVERRUN]  = overrun_q;
        SDARR[SDARR_UNDERRUN] = underrun_q;
        SDARR[SDARR_BUSY]     = (state_q != ST_IDLE);
    end

    assign SDA_OE    = sda_oe_q;
    assign TX_EMPTY  = tx_empty_q;
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bus-master driver issues directed transfers and queues
// the expected observations; a negedge monitor pops and compares them.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int PH = 20;
  localparam int K_OE = 0, K_SDARR = 1, K_TXE = 2, K_STATE = 3, K_RDBYTE = 4, K_OESEEN = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scl_bus = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_oe;
  logic [15:0] mdr = 16'h0000;
  logic        ld_sdatr = 1'b0;
  logic        rd_sdarr = 1'b0;
  logic [15:0] sdarr;
  logic        tx_empty;
  i2c_state_e  state_dbg;

  logic [15:0] exp_q[$];
  int          kind_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [7:0]  rd_byte_obs = 8'h00;
  int          oe_count = 0;
  int          oe_base = 0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target dut (
    .clk      (clk),
    .reset    (reset),
    .SCL_BUS  (scl_bus),
    .SDA_IN   (sda_line),
    .SDA_OE   (sda_oe),
    .MDR      (mdr),
    .LD_SDATR (ld_sdatr),
    .RD_SDARR (rd_sdarr),
    .SDARR    (sdarr),
    .TX_EMPTY (tx_empty),
    .STATE_DBG(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: got timeout, required finish before 200000 cycles");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
    $fatal(1, "watchdog expired");
  end

  // monitor / scoreboard
  always @(negedge clk) begin : monitor
    logic [15:0] e_v, o_v;
    int          k_v;
    string       n_v;
    if (sda_oe) oe_count++;
    while (exp_q.size() > 0) begin
      e_v = exp_q.pop_front();
      k_v = kind_q.pop_front();
      n_v = name_q.pop_front();
      case (k_v)
        K_OE:     o_v = {15'd0, sda_oe};
        K_SDARR:  o_v = sdarr;
        K_TXE:    o_v = {15'd0, tx_empty};
        K_STATE:  o_v = {13'd0, state_dbg};
        K_RDBYTE: o_v = {8'd0, rd_byte_obs};
        default:  o_v = {15'd0, (oe_count != oe_base)};
      endcase
      n_cmp++;
      if (o_v !== e_v) begin
        n_mis++;
        $display("FAIL %s: got %h, expected %h", n_v, o_v, e_v);
      end
    end
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input int k, input logic [15:0] v, input string n);
    exp_q.push_back(v);
    kind_q.push_back(k);
    name_q.push_back(n);
    wait_clk(1);
  endtask

  task automatic ld_pulse(input logic [15:0] v);
    mdr = v;
    ld_sdatr = 1'b1;
    wait_clk(1);
    ld_sdatr = 1'b0;
  endtask

  task automatic rd_pulse();
    rd_sdarr = 1'b1;
    wait_clk(1);
    rd_sdarr = 1'b0;
  endtask

  task automatic bus_start();
    sda_m = 1'b0;
    wait_clk(PH);
    scl_bus = 1'b0;
  endtask

  task automatic bus_rise_idle();
    wait_clk(2);
    sda_m = 1'b1;
    wait_clk(PH);
    scl_bus = 1'b1;
    wait_clk(PH);
  endtask

  task automatic bus_stop();
    wait_clk(2);
    sda_m = 1'b0;
    wait_clk(PH);
    scl_bus = 1'b1;
    wait_clk(PH);
    sda_m = 1'b1;
    wait_clk(PH);
  endtask

  task automatic send_bit(input logic b);
    wait_clk(2);
    sda_m = b;
    wait_clk(PH);
    scl_bus = 1'b1;
    wait_clk(PH);
    scl_bus = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic ack_cycle(input logic e, input string n);
    wait_clk(2);
    sda_m = 1'b1;
    wait_clk(PH);
    scl_bus = 1'b1;
    wait_clk(PH / 2);
    expect_val(K_OE, {15'd0, e}, n);
    wait_clk(PH / 2 - 1);
    scl_bus = 1'b0;
  endtask

  task automatic recv_byte(input logic [7:0] e, input string n);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      wait_clk(2);
      sda_m = 1'b1;
      wait_clk(PH);
      scl_bus = 1'b1;
      wait_clk(PH / 2);
      b = {b[6:0], sda_line};
      wait_clk(PH / 2);
      scl_bus = 1'b0;
    end
    rd_byte_obs = b;
    expect_val(K_RDBYTE, {8'd0, e}, n);
  endtask

  task automatic master_ack(input logic b);
    wait_clk(2);
    sda_m = b;
    wait_clk(PH);
    scl_bus = 1'b1;
    wait_clk(PH);
    scl_bus = 1'b0;
  endtask

  // stimulus
  initial begin
    wait_clk(3);
    reset = 1'b0;
    wait_clk(2);
    expect_val(K_OE,    16'h0000, "reset_oe");
    expect_val(K_SDARR, 16'h0000, "reset_sdarr");
    expect_val(K_TXE,   16'h0001, "reset_txe");
    expect_val(K_STATE, {13'd0, ST_IDLE}, "reset_state");

    // write 0xA5 to 0x50
    bus_start();
    send_byte(8'hA0);
    ack_cycle(1'b1, "wr_addr_ack");
    send_byte(8'hA5);
    ack_cycle(1'b1, "wr_data_ack");
    expect_val(K_SDARR, 16'h90A5, "wr_sdarr_busy");
    bus_stop();
    expect_val(K_SDARR, 16'h80A5, "wr_sdarr_idle");
    expect_val(K_OE,    16'h0000, "wr_oe_released");
    rd_pulse();
    expect_val(K_SDARR, 16'h00A5, "wr_sdarr_read");

    // address 0x51: never driven
    oe_base = oe_count;
    bus_start();
    send_byte(8'hA2);
    ack_cycle(1'b0, "mm_addr_nack");
    send_byte(8'h3C);
    ack_cycle(1'b0, "mm_data_nack");
    expect_val(K_STATE, {13'd0, ST_WAIT_STOP}, "mm_state");
    bus_stop();
    expect_val(K_OESEEN, 16'h0000, "mm_oe_never");
    expect_val(K_SDARR,  16'h00A5, "mm_sdarr");

    // overrun
    bus_start();
    send_byte(8'hA0);
    ack_cycle(1'b1, "ov_addr_ack");
    send_byte(8'h11);
    ack_cycle(1'b1, "ov_b1_ack");
    send_byte(8'h22);
    ack_cycle(1'b0, "ov_b2_nack");
    bus_stop();
    expect_val(K_SDARR, 16'hC011, "ov_sdarr");
    rd_pulse();
    expect_val(K_SDARR, 16'h0011, "ov_sdarr_read");

    // read 0x5A then underrun 0xFF
    ld_pulse(16'h005A);
    expect_val(K_TXE, 16'h0000, "rd_txe_loaded");
    bus_start();
    send_byte(8'hA1);
    ack_cycle(1'b1, "rd_addr_ack");
    recv_byte(8'h5A, "rd_byte1");
    expect_val(K_TXE, 16'h0001, "rd_txe_consumed");
    master_ack(1'b0);
    recv_byte(8'hFF, "rd_byte2");
    master_ack(1'b1);
    expect_val(K_STATE, {13'd0, ST_WAIT_STOP}, "rd_state");
    expect_val(K_SDARR, 16'h3011, "rd_sdarr_busy");
    bus_stop();
    expect_val(K_SDARR, 16'h2011, "rd_sdarr_idle");

    // repeated START after a partial write byte
    ld_pulse(16'h00C3);
    bus_start();
    send_byte(8'hA0);
    ack_cycle(1'b1, "rs_waddr_ack");
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    bus_rise_idle();
    bus_start();
    send_byte(8'hA1);
    ack_cycle(1'b1, "rs_raddr_ack");
    recv_byte(8'hC3, "rs_byte");
    master_ack(1'b1);
    expect_val(K_SDARR, 16'h1011, "rs_sdarr");
    bus_stop();
    expect_val(K_STATE, {13'd0, ST_IDLE}, "rs_state_idle");

    // reset while the address ACK is on the bus
    ld_pulse(16'h0077);
    expect_val(K_TXE, 16'h0000, "rst_txe_before");
    bus_start();
    send_byte(8'hA0);
    wait_clk(2);
    sda_m = 1'b1;
    wait_clk(PH);
    scl_bus = 1'b1;
    wait_clk(PH / 2);
    expect_val(K_OE, 16'h0001, "rst_oe_before");
    reset = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    expect_val(K_OE,    16'h0000, "rst_oe_after");
    expect_val(K_SDARR, 16'h0000, "rst_sdarr_after");
    expect_val(K_TXE,   16'h0001, "rst_txe_after");
    expect_val(K_STATE, {13'd0, ST_IDLE}, "rst_state_after");
    wait_clk(PH / 2);
    scl_bus = 1'b0;
    bus_rise_idle();
    bus_start();
    send_byte(8'hA0);
    ack_cycle(1'b1, "post_addr_ack");
    send_byte(8'h5C);
    ack_cycle(1'b1, "post_data_ack");
    bus_stop();
    expect_val(K_SDARR, 16'h805C, "post_sdarr");

    // report
    wait_clk(4);
    if (exp_q.size() != 0) begin
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      n_mis += exp_q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
